// File: rtl/morse_defs_pkg.sv
// Shared Morse symbol encoding, code-word geometry and FSM state encoding
// used by the encoder, the decoder and the player modules.
package morse_defs;

    localparam logic [1:0] MORSE_NONE    = 2'b00;
    localparam logic [1:0] MORSE_DOT     = 2'b01;
    localparam logic [1:0] MORSE_LINE    = 2'b11;
    localparam logic [1:0] MORSE_INVALID = 2'b10;

    localparam int MORSE_SYMBOLS = 5;
    localparam int CODE_WIDTH    = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_MARK  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Only dot and line sound; none and the reserved pattern are both silent.
    function automatic logic sym_is_mark(input logic [1:0] sym);
        logic result;
        case (sym)
            MORSE_DOT:  result = 1'b1;
            MORSE_LINE: result = 1'b1;
            default:    result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/morse_timer.sv
// Loadable down-counter; expired flags the final count of a loaded interval
// so the owner can act on the same cycle the interval ends.
module morse_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: load wins over decrement.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (enable) begin
            value_d = value_q - WIDTH'(1);
        end else begin
            value_d = value_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign expired = (value_q <= WIDTH'(1));

endmodule

// File: rtl/morse_encoder.sv
// Plays a packed five-symbol Morse word as a timed tone: dot = 1 unit,
// line = 3 units, one unit of silence after every mark.
module morse_encoder #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] code,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic [2:0] sym_count
);
    import morse_defs::*;

    localparam int TW = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [TW-1:0] DOT_TICKS  = TW'(UNIT_CYCLES);
    localparam logic [TW-1:0] LINE_TICKS = TW'(3 * UNIT_CYCLES);

    logic [2:0]  state_q, state_d;
    logic [9:0]  shift_q, shift_d;
    logic [2:0]  slots_q, slots_d;
    logic [2:0]  sym_count_q, sym_count_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_value;
    logic          tmr_enable;
    logic [TW-1:0] tmr_value;
    logic          tmr_expired;
    logic [1:0]    head_sym;

    assign head_sym = shift_q[9:8];

    morse_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .enable     (tmr_enable),
        .value      (tmr_value),
        .expired    (tmr_expired)
    );

    // Playback FSM: fetch one slot per cycle, time marks and gaps.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        slots_d        = slots_q;
        sym_count_d    = sym_count_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_enable     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d     = code;
                    slots_d     = 3'(MORSE_SYMBOLS);
                    sym_count_d = 3'd0;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                shift_d = {shift_q[7:0], 2'b00};
                slots_d = slots_q - 3'd1;
                if (sym_is_mark(head_sym)) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = (head_sym == MORSE_LINE) ? LINE_TICKS : DOT_TICKS;
                    state_d        = ST_MARK;
                end else if (slots_q == 3'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_MARK: begin
                tmr_enable = (tmr_value != '0);
                if (tmr_expired) begin
                    sym_count_d    = sym_count_q + 3'd1;
                    tmr_load       = 1'b1;
                    tmr_load_value = DOT_TICKS;
                    state_d        = ST_GAP;
                end else begin
                    state_d = ST_MARK;
                end
            end

            ST_GAP: begin
                tmr_enable = (tmr_value != '0);
                if (tmr_expired) begin
                    state_d = (slots_q != 3'd0) ? ST_FETCH : ST_DONE;
                end else begin
                    state_d = ST_GAP;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register, slot counter and symbol counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 10'd0;
            slots_q     <= 3'd0;
            sym_count_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            slots_q     <= slots_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign tone      = (state_q == ST_MARK);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4; traces are captured
// per cycle after the start edge E (bit k = cycle E+k).
module tb_morse_encoder;

    logic       clock;
    logic       reset;
    logic       start;
    logic [9:0] code;
    logic       tone;
    logic       busy;
    logic       done;
    logic [2:0] sym_count;

    int tests;
    int fails;

    logic [63:0] tone_v;
    logic [63:0] busy_v;
    logic [63:0] done_v;

    morse_encoder #(
        .UNIT_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .code      (code),
        .tone      (tone),
        .busy      (busy),
        .done      (done),
        .sym_count (sym_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Start playback and record n cycles; optionally pulse or hold start.
    task automatic capture(input logic [9:0] c, input int n, input int pulse_k, input logic hold);
        @(negedge clock);
        code   = c;
        start  = 1'b1;
        tone_v = 64'd0;
        busy_v = 64'd0;
        done_v = 64'd0;
        @(posedge clock);
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(posedge clock);
            #1;
            tone_v[k] = tone;
            busy_v[k] = busy;
            done_v[k] = done;
            start = hold || (k == pulse_k);
            if (k == pulse_k) code = 10'b11_11_11_11_11;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        code  = 10'd0;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({tone, busy, done, sym_count} !== 6'd0) begin
            fails++;
            $display("FAIL reset_outputs: got tone=%b busy=%b done=%b sym=%0d, want all 0",
                     tone, busy, done, sym_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_dot();
        capture(10'b01_00_00_00_00, 20, 0, 1'b0);
        tests++;
        if (tone_v !== rng(2, 5)) begin
            fails++;
            $display("FAIL dot_tone: got %h want %h", tone_v, rng(2, 5));
        end
        tests++;
        if (busy_v !== rng(1, 14)) begin
            fails++;
            $display("FAIL dot_busy: got %h want %h", busy_v, rng(1, 14));
        end
        tests++;
        if (done_v !== rng(14, 14)) begin
            fails++;
            $display("FAIL dot_done: got %h want %h", done_v, rng(14, 14));
        end
        tests++;
        if (sym_count !== 3'd1) begin
            fails++;
            $display("FAIL dot_sym_count: got %0d want 1", sym_count);
        end
    endtask

    task automatic test_mixed();
        logic [63:0] exp_tone;
        exp_tone = rng(2, 13) | rng(19, 22) | rng(28, 39);
        capture(10'b11_01_11_00_00, 50, 0, 1'b0);
        tests++;
        if (tone_v !== exp_tone) begin
            fails++;
            $display("FAIL mixed_tone: got %h want %h", tone_v, exp_tone);
        end
        tests++;
        if (busy_v !== rng(1, 46)) begin
            fails++;
            $display("FAIL mixed_busy: got %h want %h", busy_v, rng(1, 46));
        end
        tests++;
        if (done_v !== rng(46, 46)) begin
            fails++;
            $display("FAIL mixed_done: got %h want %h", done_v, rng(46, 46));
        end
        tests++;
        if (sym_count !== 3'd3) begin
            fails++;
            $display("FAIL mixed_sym_count: got %0d want 3", sym_count);
        end
    endtask

    task automatic test_empty();
        capture(10'd0, 10, 0, 1'b0);
        tests++;
        if (tone_v !== 64'd0) begin
            fails++;
            $display("FAIL empty_tone: got %h want 0", tone_v);
        end
        tests++;
        if (busy_v !== rng(1, 6) || done_v !== rng(6, 6)) begin
            fails++;
            $display("FAIL empty_busy_done: got busy=%h done=%h want busy=%h done=%h",
                     busy_v, done_v, rng(1, 6), rng(6, 6));
        end
        tests++;
        if (sym_count !== 3'd0) begin
            fails++;
            $display("FAIL empty_sym_count: got %0d want 0", sym_count);
        end
    endtask

    task automatic test_invalid();
        capture(10'b10_01_10_10_10, 20, 0, 1'b0);
        tests++;
        if (tone_v !== rng(3, 6)) begin
            fails++;
            $display("FAIL invalid_tone: got %h want %h", tone_v, rng(3, 6));
        end
        tests++;
        if (busy_v !== rng(1, 14) || done_v !== rng(14, 14)) begin
            fails++;
            $display("FAIL invalid_busy_done: got busy=%h done=%h want busy=%h done=%h",
                     busy_v, done_v, rng(1, 14), rng(14, 14));
        end
        tests++;
        if (sym_count !== 3'd1) begin
            fails++;
            $display("FAIL invalid_sym_count: got %0d want 1", sym_count);
        end
    endtask

    task automatic test_ignore_start();
        capture(10'b01_00_00_00_00, 20, 5, 1'b0);
        tests++;
        if (tone_v !== rng(2, 5) || busy_v !== rng(1, 14) || done_v !== rng(14, 14)) begin
            fails++;
            $display("FAIL ignore_start: got tone=%h busy=%h done=%h want tone=%h busy=%h done=%h",
                     tone_v, busy_v, done_v, rng(2, 5), rng(1, 14), rng(14, 14));
        end
        tests++;
        if (sym_count !== 3'd1) begin
            fails++;
            $display("FAIL ignore_start_sym_count: got %0d want 1", sym_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_busy;
        logic [63:0] exp_tone;
        exp_busy = rng(1, 14) | rng(16, 20);
        exp_tone = rng(2, 5) | rng(17, 20);
        capture(10'b01_00_00_00_00, 20, 0, 1'b1);
        tests++;
        if (busy_v !== exp_busy) begin
            fails++;
            $display("FAIL held_start_busy: got %h want %h", busy_v, exp_busy);
        end
        tests++;
        if (tone_v !== exp_tone || done_v !== rng(14, 14)) begin
            fails++;
            $display("FAIL held_start_tone_done: got tone=%h done=%h want tone=%h done=%h",
                     tone_v, done_v, exp_tone, rng(14, 14));
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic seen;
        capture(10'b11_00_00_00_00, 6, 0, 1'b0);
        tests++;
        if (tone !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre_tone: got %b want 1", tone);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        tests++;
        if (tone !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sym_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got tone=%b busy=%b done=%b sym=%0d want 0 0 0 0",
                     tone, busy, done, sym_count);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            seen = seen | done | busy | tone;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got activity=%b want 0", seen);
        end
        capture(10'b01_00_00_00_00, 20, 0, 1'b0);
        tests++;
        if (tone_v !== rng(2, 5) || done_v !== rng(14, 14) || sym_count !== 3'd1) begin
            fails++;
            $display("FAIL reset_mid_replay: got tone=%h done=%h sym=%0d want tone=%h done=%h sym=1",
                     tone_v, done_v, sym_count, rng(2, 5), rng(14, 14));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_dot();
        test_mixed();
        test_empty();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
